// File: rtl/xaui_link_sequencer_if.sv
// Control/status bundle between one XAUI link sequencer and its 4-lane GTX slice.
// master: the sequencer side; slave: the transceiver/status side.
interface xaui_link_sequencer_if;
    logic        force_reset;
    logic [3:0]  mgt_rxlock;
    logic [3:0]  mgt_rxsyncok;
    logic [7:0]  mgt_rxcodevalid;
    logic [3:0]  mgt_rxbufferr;
    logic [3:0]  mgt_rxelecidle;
    logic        mgt_tx_rst;
    logic        mgt_rx_rst;
    logic [3:0]  mgt_rxencommaalign;
    logic        mgt_rxenchansync;
    logic        link_up;
    logic [2:0]  seq_state;
    logic [7:0]  retry_count;
    logic [15:0] err_count;

    modport master (
        input  force_reset, mgt_rxlock, mgt_rxsyncok, mgt_rxcodevalid, mgt_rxbufferr,
               mgt_rxelecidle,
        output mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync, link_up,
               seq_state, retry_count, err_count
    );

    modport slave (
        output force_reset, mgt_rxlock, mgt_rxsyncok, mgt_rxcodevalid, mgt_rxbufferr,
               mgt_rxelecidle,
        input  mgt_tx_rst, mgt_rx_rst, mgt_rxencommaalign, mgt_rxenchansync, link_up,
               seq_state, retry_count, err_count
    );
endinterface

// File: rtl/xaui_link_sequencer.sv
// Bring-up/recovery sequencer for one 4-lane XAUI port: reset, lock, align, chansync, up.
// Define XAUI_SEQ_ERRCNT_EN to build the code-error counter behind err_count.
module xaui_link_sequencer #(
    parameter int unsigned RST_CYCLES      = 64,
    parameter int unsigned LOCK_TIMEOUT    = 65535,
    parameter int unsigned ALIGN_TIMEOUT   = 65535,
    parameter int unsigned STABLE_CYCLES   = 255,
    parameter int unsigned CHANSYNC_CYCLES = 32
) (
    input logic                   xaui_clk,
    input logic                   mgt_reset,
    xaui_link_sequencer_if.master link
);

    typedef enum logic [2:0] {
        StReset    = 3'd0,
        StWaitLock = 3'd1,
        StAlign    = 3'd2,
        StChansync = 3'd3,
        StUp       = 3'd4
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] stable_q, stable_d;
    logic [7:0]  retry_q, retry_d;
    logic [16:0] cnt_inc;
    logic        lock_all, sync_all, buferr_any, clean;
    logic        tx_rst_q, rx_rst_q, chansync_q, link_up_q;
    logic [3:0]  align_q;

    assign lock_all   = &link.mgt_rxlock;
    assign sync_all   = &link.mgt_rxsyncok;
    assign buferr_any = |link.mgt_rxbufferr;
    assign clean      = lock_all & sync_all & (&link.mgt_rxcodevalid) & ~buferr_any &
                        ~(|link.mgt_rxelecidle);
    // cnt_inc is the number of cycles spent in the current state including this one
    assign cnt_inc    = {1'b0, cnt_q} + 17'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_inc[15:0];
        stable_d = stable_q;
        retry_d  = retry_q;
        unique case (state_q)
            StReset: begin
                if (cnt_q == 16'(RST_CYCLES - 1)) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (cnt_inc == 17'(LOCK_TIMEOUT)) state_d = StReset;
                else if (lock_all)                state_d = StAlign;
            end
            StAlign: begin
                if (cnt_inc == 17'(ALIGN_TIMEOUT))       state_d  = StReset;
                else if (stable_q == 16'(STABLE_CYCLES)) state_d  = StChansync;
                else if (clean)                          stable_d = stable_q + 16'd1;
                else                                     stable_d = '0;
            end
            StChansync: begin
                if (!clean)                                state_d = StAlign;
                else if (cnt_inc == 17'(CHANSYNC_CYCLES)) state_d = StUp;
            end
            StUp: begin
                if (!lock_all || !sync_all || buferr_any) state_d = StReset;
            end
            default: state_d = StReset;
        endcase

        if (link.force_reset) state_d = StReset;

        if (state_d != state_q) begin
            cnt_d    = '0;
            stable_d = '0;
        end
        // Holding force keeps the reset pass from starting until it is released
        if (link.force_reset) cnt_d = '0;

        if (state_d == StReset && state_q != StReset && retry_q != 8'hFF) begin
            retry_d = retry_q + 8'd1;
        end
    end

    always_ff @(posedge xaui_clk) begin
        if (mgt_reset) begin
            state_q    <= StReset;
            cnt_q      <= '0;
            stable_q   <= '0;
            retry_q    <= '0;
            tx_rst_q   <= 1'b1;
            rx_rst_q   <= 1'b1;
            align_q    <= '0;
            chansync_q <= 1'b0;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            retry_q    <= retry_d;
            tx_rst_q   <= (state_d == StReset);
            rx_rst_q   <= (state_d == StReset);
            align_q    <= {4{state_d == StAlign}};
            chansync_q <= (state_d == StChansync);
            link_up_q  <= (state_d == StUp);
        end
    end

`ifdef XAUI_SEQ_ERRCNT_EN
    logic [15:0] err_q;

    always_ff @(posedge xaui_clk) begin
        if (mgt_reset || link.force_reset) begin
            err_q <= '0;
        end else if (state_q == StUp && !(&link.mgt_rxcodevalid) && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign link.err_count = err_q;
`else
    assign link.err_count = 16'h0;
`endif

    assign link.mgt_tx_rst         = tx_rst_q;
    assign link.mgt_rx_rst         = rx_rst_q;
    assign link.mgt_rxencommaalign = align_q;
    assign link.mgt_rxenchansync   = chansync_q;
    assign link.link_up            = link_up_q;
    assign link.seq_state          = state_q;
    assign link.retry_count        = retry_q;

endmodule

// File: tb/tb_xaui_link_sequencer.sv
// Directed bench for xaui_link_sequencer: table-driven bring-up/recovery timeline plus
// hand-written force, align-drop, chansync-drop and lock-timeout sequences.
module tb_xaui_link_sequencer;

    localparam logic [15:0] ERR5 =
`ifdef XAUI_SEQ_ERRCNT_EN
        16'd5;
`else
        16'd0;
`endif

    typedef struct {
        int unsigned adv;
        logic [3:0]  lock;
        logic [3:0]  sync;
        logic [7:0]  cv;
        logic [3:0]  berr;
        logic [2:0]  st;
        logic        tx;
        logic [3:0]  al;
        logic        cs;
        logic        up;
        logic [7:0]  rt;
        logic [15:0] er;
    } vec_t;

    logic clk;
    logic mgt_reset;
    int   n_checks;
    int   n_err;

    xaui_link_sequencer_if link_if ();

    xaui_link_sequencer #(
        .RST_CYCLES     (64),
        .LOCK_TIMEOUT   (100),
        .ALIGN_TIMEOUT  (65535),
        .STABLE_CYCLES  (255),
        .CHANSYNC_CYCLES(32)
    ) dut (
        .xaui_clk (clk),
        .mgt_reset(mgt_reset),
        .link     (link_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [2:0] st, input logic tx,
                             input logic [3:0] al, input logic cs, input logic up,
                             input logic [7:0] rt, input logic [15:0] er);
        check({tag, ".seq_state"},   32'(link_if.seq_state),          32'(st));
        check({tag, ".tx_rst"},      32'(link_if.mgt_tx_rst),         32'(tx));
        check({tag, ".rx_rst"},      32'(link_if.mgt_rx_rst),         32'(tx));
        check({tag, ".commaalign"},  32'(link_if.mgt_rxencommaalign), 32'(al));
        check({tag, ".chansync"},    32'(link_if.mgt_rxenchansync),   32'(cs));
        check({tag, ".link_up"},     32'(link_if.link_up),            32'(up));
        check({tag, ".retry_count"}, 32'(link_if.retry_count),        32'(rt));
        check({tag, ".err_count"},   32'(link_if.err_count),          32'(er));
    endtask

    task automatic set_clean();
        link_if.force_reset     = 1'b0;
        link_if.mgt_rxlock      = 4'hF;
        link_if.mgt_rxsyncok    = 4'hF;
        link_if.mgt_rxcodevalid = 8'hFF;
        link_if.mgt_rxbufferr   = 4'h0;
        link_if.mgt_rxelecidle  = 4'h0;
    endtask

    vec_t vecs[15];

    initial begin
        n_checks = 0;
        n_err    = 0;
        // Timeline relative to reset release (R) with all lanes clean
        vecs[0]  = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd0, 16'd0};
        vecs[1]  = '{62,  4'hF, 4'hF, 8'hFF, 4'h0, 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd0, 16'd0};
        vecs[2]  = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 16'd0};
        vecs[3]  = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd2, 1'b0, 4'hF, 1'b0, 1'b0, 8'd0, 16'd0};
        vecs[4]  = '{255, 4'hF, 4'hF, 8'hFF, 4'h0, 3'd2, 1'b0, 4'hF, 1'b0, 1'b0, 8'd0, 16'd0};
        vecs[5]  = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd3, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0, 16'd0};
        vecs[6]  = '{31,  4'hF, 4'hF, 8'hFF, 4'h0, 3'd3, 1'b0, 4'h0, 1'b1, 1'b0, 8'd0, 16'd0};
        vecs[7]  = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd4, 1'b0, 4'h0, 1'b0, 1'b1, 8'd0, 16'd0};
        // Code errors in UP: counted (when built in) but link stays up
        vecs[8]  = '{5,   4'hF, 4'hF, 8'hFE, 4'h0, 3'd4, 1'b0, 4'h0, 1'b0, 1'b1, 8'd0, ERR5};
        vecs[9]  = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd4, 1'b0, 4'h0, 1'b0, 1'b1, 8'd0, ERR5};
        // One-cycle buffer error on lane 2 (P), then full re-bring-up
        vecs[10] = '{1,   4'hF, 4'hF, 8'hFF, 4'h4, 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd1, ERR5};
        vecs[11] = '{63,  4'hF, 4'hF, 8'hFF, 4'h0, 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd1, ERR5};
        vecs[12] = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd1, ERR5};
        vecs[13] = '{288, 4'hF, 4'hF, 8'hFF, 4'h0, 3'd3, 1'b0, 4'h0, 1'b1, 1'b0, 8'd1, ERR5};
        vecs[14] = '{1,   4'hF, 4'hF, 8'hFF, 4'h0, 3'd4, 1'b0, 4'h0, 1'b0, 1'b1, 8'd1, ERR5};

        set_clean();
        mgt_reset = 1'b1;
        cyc(3);
        check_all("in_reset", 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd0, 16'd0);
        mgt_reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            link_if.mgt_rxlock      = vecs[i].lock;
            link_if.mgt_rxsyncok    = vecs[i].sync;
            link_if.mgt_rxcodevalid = vecs[i].cv;
            link_if.mgt_rxbufferr   = vecs[i].berr;
            cyc(vecs[i].adv);
            check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].tx, vecs[i].al, vecs[i].cs,
                      vecs[i].up, vecs[i].rt, vecs[i].er);
        end

        // Force held 10 cycles in UP: one retry, err cleared, reset pass starts on release
        link_if.force_reset = 1'b1;
        cyc(1);
        check_all("force_first", 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd2, 16'd0);
        cyc(9);
        check_all("force_held", 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd2, 16'd0);
        link_if.force_reset = 1'b0;
        cyc(63);
        check("force_rst_still_high", 32'(link_if.mgt_tx_rst), 32'd1);
        cyc(1);
        check_all("force_rst_fall", 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd2, 16'd0);

        // ALIGN: drop sync on lane 0 at stable count 200; needs 255 fresh clean cycles
        cyc(1);
        check("align_entry", 32'(link_if.seq_state), 32'd2);
        cyc(200);
        link_if.mgt_rxsyncok = 4'hE;
        cyc(1);
        check("align_drop", 32'(link_if.seq_state), 32'd2);
        link_if.mgt_rxsyncok = 4'hF;
        cyc(255);
        check("align_hold", 32'(link_if.seq_state), 32'd2);
        cyc(1);
        check_all("chansync_reach", 3'd3, 1'b0, 4'h0, 1'b1, 1'b0, 8'd2, 16'd0);

        // CHANSYNC: one electrical-idle cycle sends it back to ALIGN without a retry
        cyc(5);
        link_if.mgt_rxelecidle = 4'h2;
        cyc(1);
        check_all("chansync_drop", 3'd2, 1'b0, 4'hF, 1'b0, 1'b0, 8'd2, 16'd0);
        link_if.mgt_rxelecidle = 4'h0;

        // mgt_reset mid-sequence, then lane 3 never locks: WAIT_LOCK times out after 100
        mgt_reset = 1'b1;
        cyc(1);
        check_all("mid_reset", 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd0, 16'd0);
        link_if.mgt_rxlock = 4'h7;
        cyc(2);
        mgt_reset = 1'b0;
        cyc(64);
        check_all("lock_wait1", 3'd1, 1'b0, 4'h0, 1'b0, 1'b0, 8'd0, 16'd0);
        cyc(99);
        check("lock_wait1_end", 32'(link_if.seq_state), 32'd1);
        cyc(1);
        check_all("lock_timeout1", 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd1, 16'd0);
        cyc(64);
        check("lock_wait2", 32'(link_if.seq_state), 32'd1);
        cyc(100);
        check_all("lock_timeout2", 3'd0, 1'b1, 4'h0, 1'b0, 1'b0, 8'd2, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
